hdr_wr_ctrl: RTL and testbench

Frame-buffer write controller directly downstream of the tone-mapping stage. It accepts 128-bit words, each holding eight packed RGB565 pixels, through the `wr_req`/`wr_data` strobe interface. Words are buffered in a small FIFO and issued to the SDRAM controller with a request/acknowledge handshake. Addresses are generated across three rotating frame buffers, and the most recently completed buffer is published to the display/read side.

---
 rtl/hdr_pkg.sv | 29 ++
 rtl/hdr_wr_fifo.sv | 76 +++++++
 rtl/hdr_wr_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_hdr_wr_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hdr_pkg.sv
// +------------------------------------------------------------------+
// | hdr_pkg : shared types and constants for the HDR frame writer     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

package hdr_pkg;

  localparam int unsigned HDR_FRAME_WORDS = 38400;
  localparam int unsigned HDR_WORD_W      = 128;

  typedef enum logic [0:0] {
    WR_IDLE = 1'b0,
    WR_REQ  = 1'b1
  } wr_state_e;

  // Start offset of each of the three rotating frame buffers.
  function automatic logic [31:0] buf_offset(input logic [1:0] idx,
                                             input int unsigned frame_words);
    case (idx)
      2'd1:    return frame_words;
      2'd2:    return 2 * frame_words;
      default: return 32'd0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/hdr_wr_fifo.sv
// +------------------------------------------------------------------+
// | hdr_wr_fifo : show-ahead synchronous FIFO with registered         |
// |               almost-full flag. Rev 1.0                           |
// +------------------------------------------------------------------+
`default_nettype none

module hdr_wr_fifo #(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned WIDTH    = 128,
  parameter int unsigned AF_LEVEL = DEPTH - 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_data,
  output logic [WIDTH-1:0]           next_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             af_q, af_d;
  logic             push_ok, pop_ok;

  assign full        = (count_q == CNT_W'(DEPTH));
  assign empty       = (count_q == '0);
  assign count       = count_q;
  assign almost_full = af_q;
  assign head_data   = mem_q[rd_ptr_q];
  assign next_data   = mem_q[rd_ptr_q + PTR_W'(1)];

  // A pop frees the slot on the same edge, so a full FIFO still accepts a push.
  assign push_ok = push && (!full || pop);
  assign pop_ok  = pop && !empty;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push_ok && !pop_ok)      count_d = count_q + CNT_W'(1);
    else if (!push_ok && pop_ok) count_d = count_q - CNT_W'(1);
    af_d = (count_d >= CNT_W'(AF_LEVEL));
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      af_q     <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      af_q     <= af_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/hdr_wr_ctrl.sv
// +------------------------------------------------------------------+
// | hdr_wr_ctrl : triple-buffered frame writer to SDRAM controller.   |
// | Optional stats outputs with HDR_WR_STATS_EN. Rev 1.0              |
// +------------------------------------------------------------------+
`default_nettype none

module hdr_wr_ctrl
  import hdr_pkg::*;
#(
  parameter int unsigned       FRAME_WORDS = HDR_FRAME_WORDS,
  parameter int unsigned       FIFO_DEPTH  = 8,
  parameter int unsigned       ADDR_W      = 24,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_req,
  input  logic [HDR_WORD_W-1:0] wr_data,
  input  logic                  frame_sync,
  output logic                  wr_busy,
  output logic                  mem_wr_req,
  output logic [ADDR_W-1:0]     mem_wr_addr,
  output logic [HDR_WORD_W-1:0] mem_wr_data,
  input  logic                  mem_ack,
  output logic [2:0]            last_frame,
  output logic                  frame_wr_done,
  output logic                  err_overflow
`ifdef HDR_WR_STATS_EN
  ,
  output logic [15:0]           frame_count,
  output logic [15:0]           drop_count
`endif
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  wr_state_e             state_q, state_d;
  logic                  in_vld_q, in_vld_d;
  logic [HDR_WORD_W-1:0] in_data_q, in_data_d;
  logic [1:0]            wr_buf_q, wr_buf_d;
  logic [15:0]           word_cnt_q, word_cnt_d;
  logic [2:0]            last_frame_q, last_frame_d;
  logic                  done_q, done_d;
  logic                  ovf_q, ovf_d;
  logic                  stale_q, stale_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [HDR_WORD_W-1:0] data_q, data_d;

  logic                  ack, drop, load;
  logic [HDR_WORD_W-1:0] load_data;
  logic [HDR_WORD_W-1:0] fifo_head, fifo_next;
  logic [CNT_W-1:0]      fifo_count;
  logic                  fifo_full, fifo_empty, fifo_af;

  assign ack  = mem_ack && (state_q == WR_REQ);
  assign drop = in_vld_q && fifo_full && !ack;

  hdr_wr_fifo #(
    .DEPTH    (FIFO_DEPTH),
    .WIDTH    (HDR_WORD_W),
    .AF_LEVEL (FIFO_DEPTH - 2)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push        (in_vld_q),
    .push_data   (in_data_q),
    .pop         (ack),
    .head_data   (fifo_head),
    .next_data   (fifo_next),
    .count       (fifo_count),
    .full        (fifo_full),
    .empty       (fifo_empty),
    .almost_full (fifo_af)
  );

  always_comb begin
    state_d      = state_q;
    in_vld_d     = wr_req;
    in_data_d    = wr_data;
    wr_buf_d     = wr_buf_q;
    word_cnt_d   = word_cnt_q;
    last_frame_d = last_frame_q;
    done_d       = 1'b0;
    ovf_d        = ovf_q | drop;
    stale_d      = stale_q;
    addr_d       = addr_q;
    data_d       = data_q;
    load         = 1'b0;
    load_data    = fifo_head;

    // A request that was outstanding across frame_sync is written but not counted.
    if (ack && !stale_q) begin
      if (word_cnt_q == 16'(FRAME_WORDS - 1)) begin
        word_cnt_d   = '0;
        last_frame_d = 3'b001 << wr_buf_q;
        wr_buf_d     = (wr_buf_q == 2'd2) ? 2'd0 : wr_buf_q + 2'd1;
        done_d       = 1'b1;
      end else begin
        word_cnt_d = word_cnt_q + 16'd1;
      end
    end
    if (frame_sync) word_cnt_d = '0;
    if (ack)        stale_d    = 1'b0;

    case (state_q)
      WR_IDLE: begin
        if (!fifo_empty) begin
          state_d   = WR_REQ;
          load      = 1'b1;
          load_data = fifo_head;
        end
      end
      WR_REQ: begin
        if (ack) begin
          if (fifo_count >= CNT_W'(2)) begin
            load      = 1'b1;
            load_data = fifo_next;
          end else begin
            state_d = WR_IDLE;
          end
        end
      end
      default: state_d = WR_IDLE;
    endcase

    if (load) begin
      addr_d = BASE_ADDR + ADDR_W'(buf_offset(wr_buf_d, FRAME_WORDS)) + ADDR_W'(word_cnt_d);
      data_d = load_data;
    end
    if (frame_sync && (state_d == WR_REQ) && !load) stale_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= WR_IDLE;
      in_vld_q     <= 1'b0;
      in_data_q    <= '0;
      wr_buf_q     <= 2'd0;
      word_cnt_q   <= '0;
      last_frame_q <= 3'b000;
      done_q       <= 1'b0;
      ovf_q        <= 1'b0;
      stale_q      <= 1'b0;
      addr_q       <= BASE_ADDR;
      data_q       <= '0;
    end else begin
      state_q      <= state_d;
      in_vld_q     <= in_vld_d;
      in_data_q    <= in_data_d;
      wr_buf_q     <= wr_buf_d;
      word_cnt_q   <= word_cnt_d;
      last_frame_q <= last_frame_d;
      done_q       <= done_d;
      ovf_q        <= ovf_d;
      stale_q      <= stale_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
    end
  end

  assign wr_busy       = fifo_af;
  assign mem_wr_req    = (state_q == WR_REQ);
  assign mem_wr_addr   = addr_q;
  assign mem_wr_data   = data_q;
  assign last_frame    = last_frame_q;
  assign frame_wr_done = done_q;
  assign err_overflow  = ovf_q;

`ifdef HDR_WR_STATS_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    frame_cnt_d = done_d ? frame_cnt_q + 16'd1 : frame_cnt_q;
    drop_cnt_d  = (drop && drop_cnt_q != 16'hFFFF) ? drop_cnt_q + 16'd1 : drop_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign frame_count = frame_cnt_q;
  assign drop_count  = drop_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hdr_wr_ctrl.sv
// +------------------------------------------------------------------+
// | tb_hdr_wr_ctrl : directed self-checking bench for hdr_wr_ctrl     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module tb_hdr_wr_ctrl;

  localparam int unsigned FW   = 20;
  localparam logic [23:0] BASE = 24'h000040;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         wr_req = 1'b0;
  logic [127:0] wr_data = '0;
  logic         frame_sync = 1'b0;
  logic         mem_ack = 1'b0;
  logic         wr_busy, mem_wr_req, frame_wr_done, err_overflow;
  logic [23:0]  mem_wr_addr;
  logic [127:0] mem_wr_data;
  logic [2:0]   last_frame;
`ifdef HDR_WR_STATS_EN
  logic [15:0]  frame_count, drop_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  hdr_wr_ctrl #(
    .FRAME_WORDS (FW),
    .FIFO_DEPTH  (8),
    .ADDR_W      (24),
    .BASE_ADDR   (BASE)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .wr_req        (wr_req),
    .wr_data       (wr_data),
    .frame_sync    (frame_sync),
    .wr_busy       (wr_busy),
    .mem_wr_req    (mem_wr_req),
    .mem_wr_addr   (mem_wr_addr),
    .mem_wr_data   (mem_wr_data),
    .mem_ack       (mem_ack),
    .last_frame    (last_frame),
    .frame_wr_done (frame_wr_done),
    .err_overflow  (err_overflow)
`ifdef HDR_WR_STATS_EN
    ,
    .frame_count   (frame_count),
    .drop_count    (drop_count)
`endif
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [127:0] d);
    wr_req  = 1'b1;
    wr_data = d;
    tick();
    wr_req  = 1'b0;
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (mem_wr_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_req"}, 128'(mem_wr_req), 128'd1);
  endtask

  task automatic serve(input string tag, input logic [23:0] ea, input logic [127:0] ed,
                       input logic sync);
    wait_req(tag);
    chk({tag, "_addr"}, 128'(mem_wr_addr), 128'(ea));
    chk({tag, "_data"}, mem_wr_data, ed);
    mem_ack    = 1'b1;
    frame_sync = sync;
    tick();
    mem_ack    = 1'b0;
    frame_sync = 1'b0;
  endtask

  task automatic put(input string tag, input logic [23:0] ea, input logic [127:0] ed,
                     input logic sync);
    send(ed);
    serve(tag, ea, ed, sync);
  endtask

  function automatic logic [127:0] pat(input int a, input int b);
    return {32'(a), 32'(b), 64'hA5A5_5A5A_C3C3_3C3C};
  endfunction

  function automatic logic [23:0] fa(input int bufi, input int w);
    return 24'(int'(BASE) + bufi * int'(FW) + w);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] d0;
    d0 = 128'h0123456789ABCDEF_FEDCBA9876543210;

    // reset state
    repeat (3) tick();
    chk("rst_req",  128'(mem_wr_req), 128'd0);
    chk("rst_addr", 128'(mem_wr_addr), 128'(BASE));
    chk("rst_data", mem_wr_data, 128'd0);
    chk("rst_busy", 128'(wr_busy), 128'd0);
    chk("rst_last", 128'(last_frame), 128'd0);
    chk("rst_done", 128'(frame_wr_done), 128'd0);
    chk("rst_ovf",  128'(err_overflow), 128'd0);
    rst_n = 1'b1;
    tick();

    // single word: request visible two edges after the sampling edge
    send(d0);
    chk("lat_n0", 128'(mem_wr_req), 128'd0);
    tick();
    chk("lat_n1", 128'(mem_wr_req), 128'd0);
    tick();
    chk("lat_n2", 128'(mem_wr_req), 128'd1);
    chk("single_addr", 128'(mem_wr_addr), 128'(BASE));
    chk("single_data", mem_wr_data, d0);
    repeat (2) tick();
    chk("single_hold_req",  128'(mem_wr_req), 128'd1);
    chk("single_hold_data", mem_wr_data, d0);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("single_idle", 128'(mem_wr_req), 128'd0);

    // burst of 8 with ack low, then back-to-back drain
    for (int i = 0; i < 8; i++) begin
      wr_req  = 1'b1;
      wr_data = pat(16'h100, i);
      tick();
      if (i == 5) chk("busy_cnt5", 128'(wr_busy), 128'd0);
      if (i == 6) chk("busy_cnt6", 128'(wr_busy), 128'd1);
    end
    wr_req = 1'b0;
    tick();
    chk("burst_busy_full", 128'(wr_busy), 128'd1);
    chk("burst_no_ovf", 128'(err_overflow), 128'd0);
    mem_ack = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("burst%0d_req", i),  128'(mem_wr_req), 128'd1);
      chk($sformatf("burst%0d_addr", i), 128'(mem_wr_addr), 128'(fa(0, 1 + i)));
      chk($sformatf("burst%0d_data", i), mem_wr_data, pat(16'h100, i));
      tick();
    end
    mem_ack = 1'b0;
    chk("burst_idle", 128'(mem_wr_req), 128'd0);
    chk("burst_busy_clr", 128'(wr_busy), 128'd0);

    // overflow: 10 words, ack low; words 9 and 10 are lost
    for (int i = 0; i < 10; i++) begin
      wr_req  = 1'b1;
      wr_data = 128'(i + 1);
      tick();
      if (i == 8) chk("ovf_before9", 128'(err_overflow), 128'd0);
      if (i == 9) chk("ovf_after9",  128'(err_overflow), 128'd1);
    end
    wr_req = 1'b0;
    tick();
    for (int i = 0; i < 8; i++)
      serve($sformatf("ovf_drain%0d", i), fa(0, 9 + i), 128'(i + 1), 1'b0);
    repeat (3) tick();
    chk("ovf_empty", 128'(mem_wr_req), 128'd0);
    chk("ovf_sticky", 128'(err_overflow), 128'd1);

    // reset while a request is outstanding with words queued
    for (int i = 0; i < 3; i++) begin
      wr_req  = 1'b1;
      wr_data = pat(16'h300, i);
      tick();
    end
    wr_req = 1'b0;
    wait_req("mrst");
    rst_n = 1'b0;
    tick();
    chk("mrst_req",  128'(mem_wr_req), 128'd0);
    chk("mrst_addr", 128'(mem_wr_addr), 128'(BASE));
    chk("mrst_data", mem_wr_data, 128'd0);
    chk("mrst_ovf",  128'(err_overflow), 128'd0);
    chk("mrst_busy", 128'(wr_busy), 128'd0);
    rst_n = 1'b1;
    repeat (3) tick();
    chk("mrst_flushed", 128'(mem_wr_req), 128'd0);

    // four full frames across the rotating buffers
    for (int f = 0; f < 4; f++) begin
      for (int w = 0; w < int'(FW); w++) begin
        put($sformatf("f%0d_w%0d", f, w), fa(f % 3, w), pat(f, w), 1'b0);
        if (w == int'(FW) - 2)
          chk($sformatf("f%0d_done_early", f), 128'(frame_wr_done), 128'd0);
      end
      chk($sformatf("f%0d_done", f), 128'(frame_wr_done), 128'd1);
      chk($sformatf("f%0d_last", f), 128'(last_frame), 128'(3'b001 << (f % 3)));
      tick();
      chk($sformatf("f%0d_done_pulse", f), 128'(frame_wr_done), 128'd0);
    end

    // frame_sync in idle mid-frame: same buffer restarts at 0
    for (int w = 0; w < 10; w++)
      put($sformatf("s_w%0d", w), fa(1, w), pat(16'h500, w), 1'b0);
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
    put("sync_restart", fa(1, 0), pat(16'h600, 0), 1'b0);
    chk("sync_last_keep", 128'(last_frame), 128'd1);

    // frame_sync while a request is outstanding: latched address kept, not counted
    send(pat(16'h700, 0));
    wait_req("stale");
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
    serve("stale", fa(1, 1), pat(16'h700, 0), 1'b0);
    put("after_stale", fa(1, 0), pat(16'h700, 1), 1'b0);

    // frame_sync coincident with the last-word ack: completion first
    for (int w = 1; w < int'(FW) - 1; w++)
      put($sformatf("t_w%0d", w), fa(1, w), pat(16'h800, w), 1'b0);
    put("sync_lastword", fa(1, int'(FW) - 1), pat(16'h900, 0), 1'b1);
    chk("sync_lastword_done", 128'(frame_wr_done), 128'd1);
    chk("sync_lastword_last", 128'(last_frame), 128'd2);
    put("next_buf_first", fa(2, 0), pat(16'h900, 1), 1'b0);
    chk("next_buf_last", 128'(last_frame), 128'd2);

`ifdef HDR_WR_STATS_EN
    chk("stats_frames", 128'(frame_count), 128'd5);
    chk("stats_drops",  128'(drop_count), 128'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
